arb2to1_24: RTL and testbench

ARB2TO1_24 -- requirements
Module: arb2to1_24

---
 rtl/arb2to1_24.sv | 103 ++++++++++
 tb/tb_arb2to1_24.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arb2to1_24.sv
// Two-requester round-robin arbiter feeding a single-word output register.
// Optional saturating per-requester grant counters are built only when ARB2TO1_STATS_EN is defined.
module arb2to1_24 #(
    parameter int k  = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          A_valid,
    input  logic [k-1:0]  A_data,
    output logic          A_ready,
    input  logic          B_valid,
    input  logic [k-1:0]  B_data,
    output logic          B_ready,
    output logic          O_valid,
    output logic [k-1:0]  O,
    input  logic          O_ready,
    output logic          SEL,
    output logic [CW-1:0] A_cnt,
    output logic [CW-1:0] B_cnt
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;
    localparam logic GRANT_A  = 1'b0;
    localparam logic GRANT_B  = 1'b1;

    logic         state_q, state_d;
    logic [k-1:0] data_q, data_d;
    logic         sel_q, sel_d;
    logic         last_q, last_d;
    logic         can_load;
    logic         prefer_b;
    logic         a_xfer, b_xfer;

    always_comb begin
        can_load = (state_q == ST_EMPTY) || O_ready;
        // On a tie the requester that did not win the last transfer goes next.
        if (A_valid && B_valid) begin
            prefer_b = (last_q == GRANT_A);
        end else begin
            prefer_b = B_valid;
        end
        a_xfer = !rst && can_load && A_valid && !prefer_b;
        b_xfer = !rst && can_load && B_valid && prefer_b;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (a_xfer || b_xfer) begin
            state_d = ST_FULL;
            data_d  = b_xfer ? B_data : A_data;
            sel_d   = b_xfer;
            last_d  = b_xfer ? GRANT_B : GRANT_A;
        end else if (state_q == ST_FULL && O_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
            last_q  <= GRANT_B;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign A_ready = a_xfer;
    assign B_ready = b_xfer;
    assign O_valid = (state_q == ST_FULL);
    assign O       = data_q;
    assign SEL     = sel_q;

`ifdef ARB2TO1_STATS_EN
    logic [CW-1:0] a_cnt_q, b_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (a_xfer && a_cnt_q != '1) a_cnt_q <= a_cnt_q + CW'(1);
            if (b_xfer && b_cnt_q != '1) b_cnt_q <= b_cnt_q + CW'(1);
        end
    end

    assign A_cnt = a_cnt_q;
    assign B_cnt = b_cnt_q;
`else
    assign A_cnt = '0;
    assign B_cnt = '0;
`endif

endmodule

// File: tb/tb_arb2to1_24.sv
// Directed bench for arb2to1_24: a queue-based model checked every cycle plus literal spot checks.
module tb_arb2to1_24;

    localparam int K  = 24;
    localparam int CW = 4;
`ifdef ARB2TO1_STATS_EN
    localparam int CNT_MAX = (1 << CW) - 1;
`else
    localparam int CNT_MAX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          A_valid, B_valid, O_ready;
    logic [K-1:0]  A_data, B_data;
    logic          A_ready, B_ready, O_valid, SEL;
    logic [K-1:0]  O;
    logic [CW-1:0] A_cnt, B_cnt;

    int errors = 0;
    int checks = 0;

    arb2to1_24 #(.k(K), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .A_valid(A_valid), .A_data(A_data), .A_ready(A_ready),
        .B_valid(B_valid), .B_data(B_data), .B_ready(B_ready),
        .O_valid(O_valid), .O(O), .O_ready(O_ready),
        .SEL(SEL), .A_cnt(A_cnt), .B_cnt(B_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the held word lives in a queue of depth 0/1; src 1 means B.
    typedef struct { logic [K-1:0] d; bit src; } word_t;
    word_t held[$];
    logic [K-1:0] m_o = '0;
    bit  m_sel = 0;
    bit  m_last_b = 1;
    int  m_acnt = 0, m_bcnt = 0;
    bit  p_pop = 0, p_push = 0;
    word_t p_word;

    always @(negedge clk) begin
        bit ea, eb;
        ea = 0; eb = 0;
        if (!rst && (held.size() == 0 || O_ready)) begin
            if (A_valid && B_valid) begin
                eb = !m_last_b;
                ea = m_last_b;
            end else begin
                ea = A_valid;
                eb = B_valid;
            end
        end
        chk("A_ready", A_ready, ea);
        chk("B_ready", B_ready, eb);
        chk("O_valid", O_valid, held.size() != 0);
        chk("O", O, m_o);
        chk("SEL", SEL, m_sel);
        chk("A_cnt", A_cnt, m_acnt);
        chk("B_cnt", B_cnt, m_bcnt);
        chk("occupancy", held.size() <= 1, 1);
        p_pop  = !rst && held.size() != 0 && O_ready;
        p_push = ea || eb;
        p_word.d   = eb ? B_data : A_data;
        p_word.src = eb;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            held.delete();
            m_o = '0; m_sel = 0; m_last_b = 1; m_acnt = 0; m_bcnt = 0;
        end else begin
            if (p_pop) void'(held.pop_front());
            if (p_push) begin
                held.push_back(p_word);
                m_o = p_word.d;
                m_sel = p_word.src;
                m_last_b = p_word.src;
                if (p_word.src) m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
                else            m_acnt = (m_acnt < CNT_MAX) ? m_acnt + 1 : CNT_MAX;
            end
        end
        p_pop = 0; p_push = 0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {A_valid, B_valid, O_ready} per cycle for a mixed backpressure run.
    logic [2:0] mix [16] = '{3'b111, 3'b110, 3'b110, 3'b001, 3'b011, 3'b101, 3'b100, 3'b111,
                             3'b000, 3'b011, 3'b111, 3'b010, 3'b101, 3'b111, 3'b001, 3'b001};

    initial begin
        rst = 1; A_valid = 0; B_valid = 0; A_data = '0; B_data = '0; O_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset O_valid", O_valid, 0);
        chk("reset O", O, 0);
        rst = 0;

        // Single requester A
        A_valid = 1; A_data = 24'h123456; O_ready = 1;
        #2;
        chk("single A_ready", A_ready, 1);
        chk("single B_ready", B_ready, 0);
        cyc();
        A_valid = 0;
        chk("single O", O, 24'h123456);
        chk("single O_valid", O_valid, 1);
        chk("single SEL", SEL, 0);

        // Round-robin after reset: A,B,A,B
        rst = 1;
        cyc();
        rst = 0;
        A_valid = 1; B_valid = 1; O_ready = 1;
        for (int i = 0; i < 4; i++) begin
            A_data = 24'hA00000 + K'(i);
            B_data = 24'hB00000 + K'(i);
            cyc();
            chk("rr SEL", SEL, i % 2);
            chk("rr O", O, (i % 2) ? 24'hB00000 + K'(i) : 24'hA00000 + K'(i));
        end
        A_valid = 0; B_valid = 0;

        // Hold a B word under backpressure
        B_valid = 1; B_data = 24'hB0B0B0;
        cyc();
        A_valid = 1; B_valid = 1; A_data = 24'hAAAAAA; B_data = 24'h0; O_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall A_ready", A_ready, 0);
            chk("stall B_ready", B_ready, 0);
            cyc();
            chk("stall O", O, 24'hB0B0B0);
            chk("stall SEL", SEL, 1);
            chk("stall O_valid", O_valid, 1);
        end

        // Drain and load on the same edge
        B_valid = 0; O_ready = 1;
        for (int i = 0; i < 6; i++) begin
            A_data = 24'h310000 + K'(i);
            cyc();
            chk("stream O_valid", O_valid, 1);
            chk("stream O", O, 24'h310000 + K'(i));
        end

        // Asynchronous reset while FULL
        A_valid = 0; O_ready = 0;
        #1;
        rst = 1;
        #1;
        chk("async O_valid", O_valid, 0);
        chk("async O", O, 0);
        chk("async SEL", SEL, 0);
        chk("async A_cnt", A_cnt, 0);
        chk("async A_ready", A_ready, 0);
        cyc();
        rst = 0;

        // Counter saturation
        A_valid = 1; O_ready = 1;
        for (int i = 0; i < 17; i++) begin
            A_data = K'(i);
            cyc();
        end
        A_valid = 0;
        chk("sat A_cnt", A_cnt, CNT_MAX);
        chk("sat B_cnt", B_cnt, 0);

        // Mixed traffic
        for (int i = 0; i < 16; i++) begin
            logic [2:0] v;
            v = mix[i];
            A_valid = v[2]; B_valid = v[1]; O_ready = v[0];
            A_data = 24'h400000 + K'(i);
            B_data = 24'h500000 + K'(i);
            cyc();
        end
        A_valid = 0; B_valid = 0; O_ready = 1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
